// File: rtl/seq_wide_adder.sv
// seq_wide_adder: multi-word adder, one word per clock through a lookahead fast_adder (optional subtract via SEQ_WIDE_ADDER_SUB_EN)
module fast_adder #(
    parameter int cascade_size = 4,
    parameter int word_width = 8
) (
    input  logic [word_width-1:0] A,
    input  logic [word_width-1:0] B,
    input  logic                  C_IN,
    output logic [word_width-1:0] R,
    output logic                  C_OUT
);
    logic [word_width-1:0] g, p;
    logic [word_width:0]   c;
    logic                  gg, pp, cg;
    assign g = A & B;
    assign p = A ^ B;
    // carries inside each cascade group are looked ahead from the group carry-in; groups chain
    always_comb begin
        c = '0;
        c[0] = C_IN;
        gg = 1'b0;
        pp = 1'b1;
        cg = 1'b0;
        for (int k = 0; k < word_width; k++) begin
            if (k % cascade_size == 0) begin
                gg = 1'b0;
                pp = 1'b1;
                cg = c[k];
            end
            gg = g[k] | (p[k] & gg);
            pp = pp & p[k];
            c[k+1] = gg | (pp & cg);
        end
    end
    assign R = p ^ c[word_width-1:0];
    assign C_OUT = c[word_width];
endmodule

module seq_wide_adder #(
    parameter int cascade_size = 4,
    parameter int word_width = 8,
    parameter int word_count = 4
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             START,
`ifdef SEQ_WIDE_ADDER_SUB_EN
    input  logic                             SUB,
`endif
    input  logic                             C_IN,
    input  logic [word_width*word_count-1:0] A,
    input  logic [word_width*word_count-1:0] B,
    output logic                             READY,
    output logic                             BUSY,
    output logic                             DONE,
    output logic [word_width*word_count-1:0] R,
    output logic                             C_OUT
);
    localparam int tot_w = word_width * word_count;
    localparam int idx_w = word_count > 1 ? $clog2(word_count) : 1;
    typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;
    state_t state, state_nx;
    logic [tot_w-1:0]      a_reg, b_reg, r_reg, b_ld;
    logic [idx_w-1:0]      idx;
    logic                  carry, c_ld, accept, last, word_co;
    logic [word_width-1:0] word_sum;
`ifdef SEQ_WIDE_ADDER_SUB_EN
    assign b_ld = SUB ? ~B : B;
    assign c_ld = SUB | C_IN;
`else
    assign b_ld = B;
    assign c_ld = C_IN;
`endif
    assign accept = START && state != ADD;
    assign last = idx == idx_w'(word_count - 1);
    fast_adder #(.cascade_size(cascade_size), .word_width(word_width)) u_add (
        .A(a_reg[idx*word_width +: word_width]),
        .B(b_reg[idx*word_width +: word_width]),
        .C_IN(carry),
        .R(word_sum),
        .C_OUT(word_co)
    );
    // state register
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else state <= state_nx;
    end
    // next state and status outputs; FIN with START goes straight back to ADD
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = START ? ADD : IDLE;
            ADD:     state_nx = last ? FIN : ADD;
            FIN:     state_nx = START ? ADD : IDLE;
            default: state_nx = IDLE;
        endcase
        READY = state != ADD;
        BUSY = state == ADD;
        DONE = state == FIN;
    end
    // operand latch on accept, then one word of sum and carry per ADD cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
            carry <= 1'b0;
            idx <= '0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= b_ld;
            carry <= c_ld;
            idx <= '0;
        end else if (state == ADD) begin
            r_reg[idx*word_width +: word_width] <= word_sum;
            carry <= word_co;
            idx <= last ? '0 : idx + 1'b1;
        end
    end
    assign R = r_reg;
    assign C_OUT = carry;
endmodule
